uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX path.
// Grants are held for a whole packet; a stall watchdog reclaims idle grants.
module uart_tx_arbiter #(
  parameter int NUM_REQ_P   = 2,
  parameter int WIDTH_P     = 8,
  parameter int TIMEOUT_P   = 1024,
  parameter int CNT_WIDTH_P = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ_P-1:0]         req_valid_i,
  input  logic [NUM_REQ_P-1:0]         req_last_i,
  input  logic [NUM_REQ_P*WIDTH_P-1:0] req_data_i,
  output logic [NUM_REQ_P-1:0]         req_ready_o,
  output logic [WIDTH_P-1:0]           data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [NUM_REQ_P-1:0]         grant_o,
  output logic                         abort_o,
  output logic [CNT_WIDTH_P-1:0]       pkt_count_o
);

  localparam int IDX_W   = $clog2(NUM_REQ_P);
  localparam int STALL_W = $clog2(TIMEOUT_P);

  localparam logic [STALL_W-1:0] STALL_MAX =
    STALL_W'(TIMEOUT_P - 1);
  localparam logic [IDX_W-1:0] LAST_RST =
    IDX_W'(NUM_REQ_P - 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IDX_W-1:0]       r_g;
  logic [IDX_W-1:0]       w_g_nxt;
  logic [IDX_W-1:0]       r_last;
  logic [IDX_W-1:0]       w_last_nxt;
  logic [IDX_W-1:0]       w_sel;
  logic                   w_sel_vld;
  logic [STALL_W-1:0]     r_stall;
  logic [STALL_W-1:0]     w_stall_nxt;
  logic                   r_abort;
  logic                   w_abort_nxt;
  logic [CNT_WIDTH_P-1:0] r_cnt;
  logic [CNT_WIDTH_P-1:0] w_cnt_nxt;

  logic w_busy;
  logic w_valid;
  logic w_last;
  logic w_xfer;

  // First valid requester after the last one served, with wrap.
  always_comb begin
    int j;
    w_sel     = '0;
    w_sel_vld = 1'b0;
    for (int i = NUM_REQ_P; i >= 1; i--) begin
      j = int'(r_last) + i;
      if (j >= NUM_REQ_P) j = j - NUM_REQ_P;
      if (req_valid_i[j]) begin
        w_sel     = IDX_W'(j);
        w_sel_vld = 1'b1;
      end
    end
  end

  assign w_busy  = (r_state == ST_BUSY);
  assign w_valid = w_busy & req_valid_i[r_g];
  assign w_last  = req_last_i[r_g];
  assign w_xfer  = w_valid & ready_i;

  assign valid_o = w_valid;
  assign data_o  = w_busy ?
    req_data_i[r_g*WIDTH_P +: WIDTH_P] : '0;

  assign grant_o = w_busy ?
    (NUM_REQ_P'(1) << r_g) : '0;
  assign req_ready_o = grant_o & {NUM_REQ_P{ready_i}};

  assign abort_o     = r_abort;
  assign pkt_count_o = r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_last_nxt  = r_last;
    w_stall_nxt = r_stall;
    w_abort_nxt = 1'b0;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_sel_vld) begin
          w_state_nxt = ST_BUSY;
          w_g_nxt     = w_sel;
          w_stall_nxt = '0;
        end
      end
      ST_BUSY: begin
        if (w_xfer) begin
          w_stall_nxt = '0;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = r_g;
            w_cnt_nxt   = r_cnt + CNT_WIDTH_P'(1);
          end
        end else if (!req_valid_i[r_g]) begin
          // Backpressure holds the counter; only a missing byte counts.
          if (r_stall == STALL_MAX) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = r_g;
            w_stall_nxt = '0;
            w_abort_nxt = 1'b1;
          end else begin
            w_stall_nxt = r_stall + STALL_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_g     <= '0;
      r_last  <= LAST_RST;
      r_stall <= '0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
      r_last  <= w_last_nxt;
      r_stall <= w_stall_nxt;
      r_abort <= w_abort_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte sources,
// expected output order queued at stimulus time, compared per scenario.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int TO = 16;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_last_i = '0;
  logic [N*W-1:0]  req_data_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [W-1:0]    data_o;
  logic            valid_o;
  logic            ready_i = 1'b1;
  logic [N-1:0]    grant_o;
  logic            abort_o;
  logic [CW-1:0]   pkt_count_o;

  uart_tx_arbiter #(
    .NUM_REQ_P  (N),
    .WIDTH_P    (W),
    .TIMEOUT_P  (TO),
    .CNT_WIDTH_P(CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_last_i (req_last_i),
    .req_data_i (req_data_i),
    .req_ready_o(req_ready_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .grant_o    (grant_o),
    .abort_o    (abort_o),
    .pkt_count_o(pkt_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       last;
    logic [7:0] data;
    int         dly;
  } src_t;

  typedef struct {
    int         g;
    logic [7:0] d;
    int         cyc;
  } obs_t;

  src_t src_q [N][$];
  obs_t exp_q[$];
  obs_t obs_q[$];
  int   gq[$];
  int   exp_gq[$];
  logic [N-1:0] gh [int];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hold = 0;
  int abort_n = 0;
  int abort_cyc = -1;
  logic [N-1:0]  abort_grant;
  logic [CW-1:0] abort_cnt;
  logic [N-1:0]  prev_grant = '0;
  logic          bad_rdy0 = 1'b0;

  function automatic int gidx(input logic [N-1:0] g);
    gidx = -1;
    for (int k = 0; k < N; k++)
      if (g == (N'(1) << k)) gidx = k;
  endfunction

  task automatic pkt(input int k, input int base, input int len,
                     input int dly, input logic fin);
    src_t s;
    obs_t e;
    for (int i = 0; i < len; i++) begin
      s.data = 8'(base + i);
      s.last = fin && (i == len - 1);
      s.dly  = (i == 0) ? dly : 0;
      src_q[k].push_back(s);
      e.g = k;
      e.d = s.data;
      e.cyc = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_sb;
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
    obs_q.delete();
    gq.delete();
    exp_gq.delete();
    hold = 0;
    abort_n = 0;
    abort_cyc = -1;
    bad_rdy0 = 1'b0;
  endtask

  task automatic do_reset;
    clear_sb();
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    ready_i     = 1'b1;
    rst_i       = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    prev_grant = '0;
  endtask

  // Drives sources at negedge, samples at negedge+1, records outputs.
  task automatic step(input int n);
    src_t s;
    obs_t o;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() > 0 && src_q[k][0].dly == 0) begin
          req_valid_i[k]         = 1'b1;
          req_last_i[k]          = src_q[k][0].last;
          req_data_i[k*W +: W]   = src_q[k][0].data;
        end else begin
          req_valid_i[k]         = 1'b0;
          req_last_i[k]          = 1'b0;
          req_data_i[k*W +: W]   = '0;
        end
      end
      ready_i = (hold == 0);
      #1;
      gh[cyc] = grant_o;
      if (valid_o && ready_i) begin
        o.g = gidx(grant_o);
        o.d = data_o;
        o.cyc = cyc;
        obs_q.push_back(o);
      end
      if (grant_o != '0 && prev_grant == '0) gq.push_back(gidx(grant_o));
      prev_grant = grant_o;
      if (abort_o) begin
        abort_n++;
        abort_cyc = cyc;
        abort_grant = grant_o;
        abort_cnt = pkt_count_o;
      end
      if (grant_o[1] && req_ready_o[0]) bad_rdy0 = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (req_valid_i[k] && req_ready_o[k]) begin
          void'(src_q[k].pop_front());
        end else if (src_q[k].size() > 0 && src_q[k][0].dly > 0) begin
          s = src_q[k][0];
          s.dly = s.dly - 1;
          src_q[k][0] = s;
        end
      end
      if (hold > 0) hold--;
      cyc++;
      @(posedge clk);
    end
  endtask

  task automatic test_reset;
    req_valid_i = '0;
    ready_i = 1'b1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    checks++;
    if (grant_o !== '0 || abort_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_grant got g=%b a=%b exp g=00 a=0", grant_o, abort_o);
    end
    checks++;
    if (pkt_count_o !== '0) begin
      failures++;
      $display("FAIL reset_count got %0d exp 0", pkt_count_o);
    end
    req_valid_i = 2'b11;
    #1;
    checks++;
    if (valid_o !== 1'b0 || req_ready_o !== '0 || data_o !== '0) begin
      failures++;
      $display("FAIL idle_outputs got v=%b r=%b d=%h exp 0/00/00",
               valid_o, req_ready_o, data_o);
    end
    req_valid_i = '0;
  endtask

  task automatic test_single_packet;
    obs_t o;
    obs_t e;
    int start;
    int i;
    do_reset();
    pkt(0, 'hA1, 3, 0, 1'b1);
    start = cyc;
    step(6);
    #1;
    checks++;
    if (gq.size() < 1 || gq[0] !== 0 || gh[start+1] !== 2'b01) begin
      failures++;
      $display("FAIL t1_grant_latency got gh=%b exp 01", gh[start+1]);
    end
    checks++;
    if (gh[start] !== '0) begin
      failures++;
      $display("FAIL t1_arb_cycle got %b exp 00", gh[start]);
    end
    i = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.g !== e.g || o.d !== e.d || o.cyc !== start + 1 + i) begin
        failures++;
        $display("FAIL t1_byte got g=%0d d=%h c=%0d exp g=%0d d=%h c=%0d",
                 o.g, o.d, o.cyc, e.g, e.d, start + 1 + i);
      end
      i++;
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL t1_leftover got exp=%0d obs=%0d exp 0/0",
               exp_q.size(), obs_q.size());
    end
    checks++;
    if (gh[start+4] !== '0) begin
      failures++;
      $display("FAIL t1_bubble got %b exp 00", gh[start+4]);
    end
    checks++;
    if (pkt_count_o !== CW'(1)) begin
      failures++;
      $display("FAIL t1_count got %0d exp 1", pkt_count_o);
    end
  endtask

  task automatic test_round_robin;
    obs_t o;
    obs_t e;
    do_reset();
    pkt(0, 'h10, 2, 0, 1'b1);
    pkt(1, 'h20, 2, 0, 1'b1);
    pkt(0, 'h30, 2, 0, 1'b1);
    pkt(1, 'h40, 2, 0, 1'b1);
    exp_gq = '{0, 1, 0, 1};
    step(20);
    #1;
    checks++;
    if (gq != exp_gq) begin
      failures++;
      $display("FAIL rr_order got %p exp %p", gq, exp_gq);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.g !== e.g || o.d !== e.d) begin
        failures++;
        $display("FAIL rr_byte got g=%0d d=%h exp g=%0d d=%h",
                 o.g, o.d, e.g, e.d);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL rr_leftover got exp=%0d obs=%0d exp 0/0",
               exp_q.size(), obs_q.size());
    end
    checks++;
    if (pkt_count_o !== CW'(4)) begin
      failures++;
      $display("FAIL rr_count got %0d exp 4", pkt_count_o);
    end
  endtask

  task automatic test_backpressure;
    obs_t o;
    obs_t e;
    do_reset();
    hold = 2000;
    pkt(1, 'h50, 3, 0, 1'b1);
    pkt(0, 'h60, 2, 5, 1'b1);
    step(2030);
    #1;
    checks++;
    if (abort_n !== 0) begin
      failures++;
      $display("FAIL bp_abort got %0d exp 0", abort_n);
    end
    checks++;
    if (bad_rdy0 !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready0 got %b exp 0", bad_rdy0);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.g !== e.g || o.d !== e.d) begin
        failures++;
        $display("FAIL bp_byte got g=%0d d=%h exp g=%0d d=%h",
                 o.g, o.d, e.g, e.d);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL bp_leftover got exp=%0d obs=%0d exp 0/0",
               exp_q.size(), obs_q.size());
    end
    checks++;
    if (pkt_count_o !== CW'(2)) begin
      failures++;
      $display("FAIL bp_count got %0d exp 2", pkt_count_o);
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    obs_t e;
    int start;
    do_reset();
    pkt(0, 'h70, 1, 0, 1'b0);
    pkt(1, 'h80, 2, 0, 1'b1);
    pkt(0, 'h90, 1, TO, 1'b1);
    exp_gq = '{0, 1, 0};
    start = cyc;
    step(30);
    #1;
    checks++;
    if (abort_n !== 1) begin
      failures++;
      $display("FAIL to_pulses got %0d exp 1", abort_n);
    end
    // Byte at start+1, TO stall cycles, release, pulse the cycle after.
    checks++;
    if (abort_cyc !== start + 1 + TO + 1) begin
      failures++;
      $display("FAIL to_when got %0d exp %0d", abort_cyc, start + TO + 2);
    end
    checks++;
    if (abort_grant !== '0 || abort_cnt !== '0) begin
      failures++;
      $display("FAIL to_state got g=%b n=%0d exp g=00 n=0",
               abort_grant, abort_cnt);
    end
    checks++;
    if (gq != exp_gq) begin
      failures++;
      $display("FAIL to_order got %p exp %p", gq, exp_gq);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.g !== e.g || o.d !== e.d) begin
        failures++;
        $display("FAIL to_byte got g=%0d d=%h exp g=%0d d=%h",
                 o.g, o.d, e.g, e.d);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL to_leftover got exp=%0d obs=%0d exp 0/0",
               exp_q.size(), obs_q.size());
    end
    checks++;
    if (pkt_count_o !== CW'(2)) begin
      failures++;
      $display("FAIL to_count got %0d exp 2", pkt_count_o);
    end
  endtask

  task automatic test_mid_reset;
    obs_t o;
    obs_t e;
    do_reset();
    pkt(0, 'hC0, 1, 0, 1'b1);
    pkt(1, 'hD0, 5, 0, 1'b1);
    step(5);
    checks++;
    if (obs_q.size() !== 3) begin
      failures++;
      $display("FAIL mr_pre_bytes got %0d exp 3", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.g !== e.g || o.d !== e.d) begin
        failures++;
        $display("FAIL mr_pre_byte got g=%0d d=%h exp g=%0d d=%h",
                 o.g, o.d, e.g, e.d);
      end
    end
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    checks++;
    if (grant_o !== '0 || valid_o !== 1'b0 || pkt_count_o !== '0) begin
      failures++;
      $display("FAIL mr_post got g=%b v=%b n=%0d exp 00/0/0",
               grant_o, valid_o, pkt_count_o);
    end
    clear_sb();
    prev_grant = '0;
    pkt(0, 'hE0, 1, 0, 1'b1);
    pkt(1, 'hF0, 1, 0, 1'b1);
    exp_gq = '{0, 1};
    step(8);
    #1;
    checks++;
    if (gq != exp_gq) begin
      failures++;
      $display("FAIL mr_order got %p exp %p", gq, exp_gq);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.g !== e.g || o.d !== e.d) begin
        failures++;
        $display("FAIL mr_byte got g=%0d d=%h exp g=%0d d=%h",
                 o.g, o.d, e.g, e.d);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL mr_leftover got exp=%0d obs=%0d exp 0/0",
               exp_q.size(), obs_q.size());
    end
  endtask

  task automatic test_count_wrap;
    obs_t o;
    obs_t e;
    int n;
    do_reset();
    for (int i = 0; i < 17; i++) pkt(0, i, 1, 0, 1'b1);
    step(45);
    #1;
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o.g !== e.g || o.d !== e.d) n++;
    end
    checks++;
    if (n != 0 || exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_bytes got bad=%0d left=%0d exp 0/0",
               n, exp_q.size());
    end
    checks++;
    if (pkt_count_o !== CW'(17 % (1 << CW))) begin
      failures++;
      $display("FAIL wrap_count got %0d exp 1", pkt_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_mid_reset();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
